// File: rtl/config_block_loader_if.sv
// config_block_loader_if
//   Groups the serial bitstream handshake and the shared latch-bus signals
//   of the configuration loader.
//
//   Handshake (one rule for the whole interface): a bit on cfg_bit_in
//   transfers on a rising clk edge where cfg_bit_valid and cfg_bit_ready are
//   both high. The source must hold cfg_bit_in/cfg_bit_valid until that edge.
//   cfg_bit_ready never depends on cfg_bit_valid.
//
//   Signals:
//     cfg_start, cfg_abort        pass control (source -> loader)
//     cfg_bit_in, cfg_bit_valid   serial data, LSB of block 0 first
//     cfg_bit_ready               loader can take a bit this cycle
//     config_out[MEM_SIZE]        shared config bus to every latch block
//     comb_set[NUM_BLOCKS]        one-hot latch write enable
//     busy, done                  pass status
//
//   Modports: master = the loader, slave = the bitstream source / observer.
interface config_block_loader_if #(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 8
);
  logic                  cfg_start;
  logic                  cfg_abort;
  logic                  cfg_bit_in;
  logic                  cfg_bit_valid;
  logic                  cfg_bit_ready;
  logic [MEM_SIZE-1:0]   config_out;
  logic [NUM_BLOCKS-1:0] comb_set;
  logic                  busy;
  logic                  done;

  modport master (
    input  cfg_start, cfg_abort, cfg_bit_in, cfg_bit_valid,
    output cfg_bit_ready, config_out, comb_set, busy, done
  );

  modport slave (
    output cfg_start, cfg_abort, cfg_bit_in, cfg_bit_valid,
    input  cfg_bit_ready, config_out, comb_set, busy, done
  );
endinterface

// File: rtl/config_block_loader.sv
// config_block_loader
//   Write side of the block-style configuration interface. Collects a serial
//   bitstream into MEM_SIZE-bit words, drives each word onto the shared
//   config bus and writes it into one of NUM_BLOCKS level-sensitive latch
//   blocks with a one-cycle one-hot comb_set strobe, framed by one setup and
//   one hold cycle in which the bus is already/still stable.
//
//   Ports:
//     clk        single clock, all state updates on posedge
//     rst_n      asynchronous active-low reset
//     bus        config_block_loader_if.master (handshake + latch bus)
//     dbg_state  current FSM state (encoding = S_* localparams below)
module config_block_loader #(
  parameter int MEM_SIZE   = 16,
  parameter int NUM_BLOCKS = 8,
  parameter int IDX_BITS   = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  parameter int CNT_BITS   = $clog2(MEM_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  config_block_loader_if.master  bus,
  output logic [2:0]             dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STROBE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [IDX_BITS-1:0]   LAST_IDX = IDX_BITS'(NUM_BLOCKS - 1);
  localparam logic [CNT_BITS-1:0]   LAST_BIT = CNT_BITS'(MEM_SIZE - 1);
  localparam logic [NUM_BLOCKS-1:0] SET_ONE  = NUM_BLOCKS'(1);

  logic [2:0]            state;
  // Only the upper MEM_SIZE-1 bits need storage: the word is complete in
  // sreg_next on the edge that accepts the final bit.
  logic [MEM_SIZE-2:0]   sreg;
  logic [MEM_SIZE-1:0]   sreg_next;
  logic [MEM_SIZE-1:0]   config_q;
  logic [NUM_BLOCKS-1:0] set_q;
  logic [CNT_BITS-1:0]   count;
  logic [IDX_BITS-1:0]   index;
  logic                  accept;

  assign accept    = (state == S_SHIFT) && bus.cfg_bit_valid;
  assign sreg_next = {bus.cfg_bit_in, sreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sreg     <= '0;
      config_q <= '0;
      set_q    <= '0;
      count    <= '0;
      index    <= '0;
    end else if (bus.cfg_abort) begin
      // Abort outranks everything, including a start seen in IDLE. The bus
      // value is left alone; only the strobe is cut.
      state <= S_IDLE;
      set_q <= '0;
      count <= '0;
      index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cfg_start) begin
            state <= S_SHIFT;
            count <= '0;
            index <= '0;
          end
        end
        S_SHIFT: begin
          if (accept) begin
            sreg  <= sreg_next[MEM_SIZE-1:1];
            count <= count + CNT_BITS'(1);
            if (count == LAST_BIT) begin
              // Bus is loaded on entry to SETUP so it is already stable in
              // the cycle before the strobe, not just during it.
              config_q <= sreg_next;
              state    <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          set_q <= SET_ONE << index;
          state <= S_STROBE;
        end
        S_STROBE: begin
          set_q <= '0;
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (index == LAST_IDX) begin
            state <= S_DONE;
          end else begin
            index <= index + IDX_BITS'(1);
            count <= '0;
            state <= S_SHIFT;
          end
        end
        S_DONE: begin
          index <= '0;
          state <= S_IDLE;
        end
        default: begin
          set_q <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status outputs decode the state register directly, so they follow the
  // asynchronous reset without waiting for a clock.
  assign bus.cfg_bit_ready = (state == S_SHIFT);
  assign bus.busy          = (state != S_IDLE);
  assign bus.done          = (state == S_DONE);
  assign bus.config_out    = config_q;
  assign bus.comb_set      = set_q;
  assign dbg_state         = state;

endmodule

// File: doc/config_block_loader.md
Name: config_block_loader

Overview:
- Write side of the block-style configuration interface.
- Accepts a serial configuration bitstream over a valid/ready handshake and assembles it into MEM_SIZE-bit words.
- Drives each word onto a shared config bus and writes it into one of NUM_BLOCKS latch blocks using a one-hot comb_set strobe.
- Provides setup and hold margins around each strobe, because the target storage is level-sensitive.

Parameters:
- MEM_SIZE, 16, bits per configured block (width of config_out).
- NUM_BLOCKS, 8, number of latch blocks on the bus (width of comb_set).
- IDX_BITS, $clog2(NUM_BLOCKS) (min 1), width of the internal block index.
- CNT_BITS, $clog2(MEM_SIZE+1), width of the internal bit counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_start  input  1  one-cycle request to begin a full configuration pass; sampled only in IDLE.
- cfg_abort  input  1  synchronous abort; returns to IDLE from any state.
- cfg_bit_in  input  1  serial config data, LSB of block 0 first.
- cfg_bit_valid  input  1  cfg_bit_in is valid this cycle.
- cfg_bit_ready  output  1  loader accepts a bit this cycle.
- config_out  output  MEM_SIZE  shared config bus to all latch blocks.
- comb_set  output  NUM_BLOCKS  one-hot latch write enable.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last block has been written.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; shift register, config_out, bit counter and block index all 0.
  - comb_set=0, cfg_bit_ready=0, busy=0, done=0.
  - Reset mid-pass forces comb_set low immediately. Already-written latches keep their contents.
- States: IDLE, SHIFT, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - cfg_start=1 -> SHIFT; index=0, count=0.
  - All other inputs are ignored.
- SHIFT:
  - cfg_bit_ready=1.
  - On valid&ready: sreg <= {cfg_bit_in, sreg[MEM_SIZE-1:1]}; count++.
  - When the MEM_SIZE-th bit is accepted -> SETUP. The first bit accepted lands in bit 0.
  - cfg_bit_valid low stalls the state indefinitely with no timeout.
- SETUP (1 cycle):
  - config_out <= sreg; comb_set=0; ready=0.
- STROBE (1 cycle):
  - comb_set = 1<<index; config_out stable.
- HOLD (1 cycle):
  - comb_set=0; config_out unchanged.
  - If index==NUM_BLOCKS-1 -> DONE; else index++, count=0, -> SHIFT.
- DONE (1 cycle):
  - done=1 -> IDLE.
  - config_out retains the last word until the next pass.
- comb_set:
  - Registered output; never more than one bit set.
  - High only in STROBE.
  - config_out does not change in the cycle before, during or after the strobe.
- Throughput: MEM_SIZE accepted bits + 3 cycles per block; done pulses 1 cycle after the final HOLD.
- cfg_abort:
  - Highest priority after reset. From any non-IDLE state -> IDLE next cycle; comb_set=0, ready=0, count=0, index=0.
  - No done pulse.
  - An abort during STROBE still leaves the strobe pulse at most 1 cycle long.
- Simultaneous cfg_abort and cfg_start in IDLE: abort wins and the loader stays IDLE.
- cfg_start while busy: ignored.
- Index never wraps within a pass; the pass terminates at NUM_BLOCKS-1.
- Bits presented while ready=0 are not consumed. The source must hold each bit until it is accepted.

Test Plan (MEM_SIZE=16, NUM_BLOCKS=4):
- Single block: start, stream 16'hA5C3 LSB-first with valid always high.
  - Required: ready low for 3 cycles after the 16th bit.
  - Required: STROBE cycle shows config_out=16'hA5C3, comb_set=4'b0001.
  - Required: the next SHIFT targets index 1.
- Full pass: stream 16'h0001, 16'h8000, 16'hFFFF, 16'h1234.
  - Required: strobes 0001, 0010, 0100, 1000 in order, each with the matching word.
  - Required: done pulses exactly once, 4*(16+3)+1 cycles after start under continuous valid; busy falls with done.
- Backpressure: toggle cfg_bit_valid every other cycle while streaming 16'h5A5A.
  - Required: exactly 16 bits consumed; config_out=16'h5A5A at strobe; no extra bits absorbed.
- Abort: assert cfg_abort after 9 bits of block 2.
  - Required: IDLE next cycle; comb_set stays 0; no done pulse.
  - Required: a new start then begins at block 0.
- Async reset: drop rst_n during STROBE of block 1.
  - Required: comb_set=0 without waiting for a clock edge; all outputs return to their reset values.
  - Required: cfg_start asserted after release restarts the pass at block 0.
- Start while busy: pulse cfg_start mid-SHIFT.
  - Required: no change in count, index or output sequence.
